single_edge_align_ctrl: RTL and testbench



---
 rtl/single_edge_align_pkg.sv | 27 ++
 rtl/align_pattern_check.sv | 20 ++
 rtl/single_edge_align_ctrl.sv | 133 +++++++++++++
 tb/tb_single_edge_align_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/single_edge_align_pkg.sv
// Shared definitions for the single-edge 40-bit TDC word-alignment controller.
package single_edge_align_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned WORD_W  = 40;

    typedef logic [STATE_W-1:0] align_state_t;

    localparam align_state_t ST_IDLE    = 3'd0;
    localparam align_state_t ST_SETTLE  = 3'd1;
    localparam align_state_t ST_CHECK   = 3'd2;
    localparam align_state_t ST_ALIGNED = 3'd3;
    localparam align_state_t ST_FAIL    = 3'd4;
    localparam align_state_t ST_MANUAL  = 3'd5;

    localparam logic [SHIFT_W-1:0] SHIFT_MAX = 4'd14;

    // Idle word, also produced by the TX idle generator.
    localparam logic [WORD_W-1:0] IDLE_PATTERN = 40'hBCBCBCBCBC;

    // Shift values beyond the shifter range fall back to zero.
    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        return (s > SHIFT_MAX) ? 4'd0 : s;
    endfunction

endpackage

// File: rtl/align_pattern_check.sv
// Tick-qualified compare of the shifted word against the idle pattern.
module align_pattern_check
    import single_edge_align_pkg::*;
#(
    parameter logic [WORD_W-1:0] PATTERN = IDLE_PATTERN
) (
    input  logic              tick,
    input  logic [WORD_W-1:0] data,
    output logic              hit,
    output logic              miss
);

    logic eq;

    // Pure combinational compare; the FSM only sees the two pulses.
    assign eq   = (data == PATTERN);
    assign hit  = tick & eq;
    assign miss = tick & ~eq;

endmodule

// File: rtl/single_edge_align_ctrl.sv
// Word-alignment controller: sweeps the shifter select until the idle
// pattern is seen on LOCK_COUNT consecutive ticks, then freezes it.
module single_edge_align_ctrl
    import single_edge_align_pkg::*;
#(
    parameter logic [WORD_W-1:0] PATTERN      = IDLE_PATTERN,
    parameter int unsigned       SETTLE_TICKS = 4,
    parameter int unsigned       LOCK_COUNT   = 64,
    parameter int unsigned       MAX_SWEEPS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              locked,
    input  logic              start,
    input  logic              man_en,
    input  logic [3:0]        man_shift,
    input  logic [WORD_W-1:0] data_40b_shifted,
    output logic [3:0]        shift,
    output logic              aligned,
    output logic              busy,
    output logic              align_fail,
    output logic [2:0]        sweep_cnt
);

    localparam int unsigned MATCH_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_TICKS + 1);

    align_state_t        state_q, state_d;
    logic [3:0]          shift_d;
    logic [2:0]          sweep_d, sweep_inc;
    logic [MATCH_W-1:0]  match_q, match_d, match_inc;
    logic [SETTLE_W-1:0] settle_q, settle_d, settle_inc;
    logic                hit, miss;

    align_pattern_check #(
        .PATTERN (PATTERN)
    ) u_check (
        .tick (tick),
        .data (data_40b_shifted),
        .hit  (hit),
        .miss (miss)
    );

    // Next-state and counter logic; override priority is man_en, locked, start.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift;
        sweep_d    = sweep_cnt;
        match_d    = match_q;
        settle_d   = settle_q;
        sweep_inc  = sweep_cnt + 3'd1;
        match_inc  = match_q + MATCH_W'(1);
        settle_inc = settle_q + SETTLE_W'(1);

        if (man_en) begin
            state_d  = ST_MANUAL;
            shift_d  = clamp_shift(man_shift);
            sweep_d  = 3'd0;
            match_d  = '0;
            settle_d = '0;
        end else if (state_q == ST_MANUAL || !locked) begin
            state_d  = ST_IDLE;
            sweep_d  = 3'd0;
            match_d  = '0;
            settle_d = '0;
        end else if (start) begin
            state_d  = ST_SETTLE;
            shift_d  = 4'd0;
            sweep_d  = 3'd0;
            match_d  = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (tick) begin
                        if (settle_inc == SETTLE_W'(SETTLE_TICKS)) begin
                            state_d  = ST_CHECK;
                            settle_d = '0;
                            match_d  = '0;
                        end else begin
                            settle_d = settle_inc;
                        end
                    end
                end
                ST_CHECK: begin
                    if (hit) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                            state_d = ST_ALIGNED;
                        end
                    end else if (miss) begin
                        match_d  = '0;
                        settle_d = '0;
                        if (shift >= SHIFT_MAX) begin
                            shift_d = 4'd0;
                            sweep_d = sweep_inc;
                            state_d = (sweep_inc == 3'(MAX_SWEEPS)) ? ST_FAIL : ST_SETTLE;
                        end else begin
                            shift_d = shift + 4'd1;
                            state_d = ST_SETTLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counters and status outputs, all registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift      <= 4'd0;
            sweep_cnt  <= 3'd0;
            match_q    <= '0;
            settle_q   <= '0;
            aligned    <= 1'b0;
            busy       <= 1'b0;
            align_fail <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift      <= shift_d;
            sweep_cnt  <= sweep_d;
            match_q    <= match_d;
            settle_q   <= settle_d;
            aligned    <= (state_d == ST_ALIGNED);
            busy       <= (state_d == ST_SETTLE) || (state_d == ST_CHECK);
            align_fail <= (state_d == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_single_edge_align_ctrl.sv
// Directed bench for single_edge_align_ctrl: per-cycle vector table plus
// multi-cycle alignment, sweep-failure, lock-loss and manual sequences.
module tb_single_edge_align_ctrl;

    localparam logic [39:0] PAT = 40'hBCBCBCBCBC;

    logic        clk = 1'b0;
    logic        rst, tick, locked, start, man_en;
    logic [3:0]  man_shift;
    logic [39:0] data_40b_shifted;
    logic [3:0]  shift;
    logic        aligned, busy, align_fail;
    logic [2:0]  sweep_cnt;

    logic        model_on;
    logic [4:0]  target;
    logic        tbl_match;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst, start, locked, man_en;
        logic [3:0] man_shift;
        logic       tick, match;
        logic [3:0] e_shift;
        logic       e_aligned, e_busy, e_fail;
        logic [2:0] e_sweep;
    } vec_t;

    vec_t tbl [17];

    single_edge_align_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .tick             (tick),
        .locked           (locked),
        .start            (start),
        .man_en           (man_en),
        .man_shift        (man_shift),
        .data_40b_shifted (data_40b_shifted),
        .shift            (shift),
        .aligned          (aligned),
        .busy             (busy),
        .align_fail       (align_fail),
        .sweep_cnt        (sweep_cnt)
    );

    always #5 clk = ~clk;

    // Ideal shifter: the pattern appears only at the target shift.
    always_comb begin
        if (model_on) data_40b_shifted = ({1'b0, shift} == target) ? PAT : ~PAT;
        else          data_40b_shifted = tbl_match ? PAT : ~PAT;
    end

    function automatic vec_t mk(input logic r, input logic s, input logic l, input logic m,
                                input logic [3:0] ms, input logic t, input logic mt,
                                input logic [3:0] es, input logic ea, input logic eb,
                                input logic ef, input logic [2:0] ew);
        vec_t v;
        v.rst = r; v.start = s; v.locked = l; v.man_en = m; v.man_shift = ms;
        v.tick = t; v.match = mt; v.e_shift = es; v.e_aligned = ea; v.e_busy = eb;
        v.e_fail = ef; v.e_sweep = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; tick = 1'b0; man_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat (gap) step();
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; locked = 1'b0; start = 1'b0; man_en = 1'b0;
        man_shift = 4'd0; model_on = 1'b0; target = 5'd0; tbl_match = 1'b0;

        //           rst st lk me ms    tk mt   shift al bz fl sw
        tbl[0]  = mk(1, 0, 0, 0, 4'd0,  0, 0,   4'd0,  0, 0, 0, 3'd0);
        tbl[1]  = mk(0, 1, 0, 0, 4'd0,  0, 0,   4'd0,  0, 0, 0, 3'd0);
        tbl[2]  = mk(0, 1, 1, 0, 4'd0,  0, 0,   4'd0,  0, 1, 0, 3'd0);
        tbl[3]  = mk(0, 0, 1, 0, 4'd0,  1, 1,   4'd0,  0, 1, 0, 3'd0);
        tbl[4]  = mk(0, 0, 1, 0, 4'd0,  1, 1,   4'd0,  0, 1, 0, 3'd0);
        tbl[5]  = mk(0, 0, 1, 0, 4'd0,  1, 1,   4'd0,  0, 1, 0, 3'd0);
        tbl[6]  = mk(0, 0, 1, 0, 4'd0,  1, 1,   4'd0,  0, 1, 0, 3'd0);
        tbl[7]  = mk(0, 0, 1, 0, 4'd0,  1, 0,   4'd1,  0, 1, 0, 3'd0);
        tbl[8]  = mk(0, 0, 1, 0, 4'd0,  0, 0,   4'd1,  0, 1, 0, 3'd0);
        tbl[9]  = mk(0, 0, 1, 1, 4'd9,  0, 0,   4'd9,  0, 0, 0, 3'd0);
        tbl[10] = mk(0, 0, 1, 1, 4'd15, 0, 0,   4'd0,  0, 0, 0, 3'd0);
        tbl[11] = mk(0, 0, 1, 1, 4'd14, 0, 0,   4'd14, 0, 0, 0, 3'd0);
        tbl[12] = mk(0, 0, 1, 0, 4'd0,  0, 0,   4'd14, 0, 0, 0, 3'd0);
        tbl[13] = mk(0, 1, 1, 0, 4'd0,  0, 0,   4'd0,  0, 1, 0, 3'd0);
        tbl[14] = mk(0, 1, 0, 0, 4'd0,  0, 0,   4'd0,  0, 0, 0, 3'd0);
        tbl[15] = mk(0, 0, 0, 1, 4'd3,  0, 0,   4'd3,  0, 0, 0, 3'd0);
        tbl[16] = mk(0, 0, 0, 0, 4'd0,  0, 0,   4'd0,  0, 0, 0, 3'd0);
        tbl[16].rst = 1'b1;

        // Per-cycle vector table.
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; locked = tbl[i].locked;
            man_en = tbl[i].man_en; man_shift = tbl[i].man_shift;
            tick = tbl[i].tick; tbl_match = tbl[i].match;
            step();
            chk($sformatf("vec%0d_shift", i),   8'(shift),      8'(tbl[i].e_shift));
            chk($sformatf("vec%0d_aligned", i), 8'(aligned),    8'(tbl[i].e_aligned));
            chk($sformatf("vec%0d_busy", i),    8'(busy),       8'(tbl[i].e_busy));
            chk($sformatf("vec%0d_fail", i),    8'(align_fail), 8'(tbl[i].e_fail));
            chk($sformatf("vec%0d_sweep", i),   8'(sweep_cnt),  8'(tbl[i].e_sweep));
        end
        rst = 1'b0; start = 1'b0; tick = 1'b0; man_en = 1'b0; locked = 1'b1;
        model_on = 1'b1;

        // Alignment at shift 5: 6*4 + 5 + 64 = 93 ticks.
        do_reset(); target = 5'd5;
        pulse_start();
        run_ticks(5, 0);
        chk("a5_shift_after_first_miss", 8'(shift), 8'd1);
        run_ticks(87, 0);
        chk("a5_not_aligned_92", 8'(aligned), 8'd0);
        chk("a5_shift_92", 8'(shift), 8'd5);
        run_ticks(1, 0);
        chk("a5_aligned_93", 8'(aligned), 8'd1);
        chk("a5_busy_93", 8'(busy), 8'd0);
        chk("a5_sweep_93", 8'(sweep_cnt), 8'd0);
        run_ticks(5, 0);
        chk("a5_aligned_hold", 8'(aligned), 8'd1);

        // Never matches: 4 sweeps of 15*5 ticks, fail after tick 300.
        do_reset(); target = 5'd31;
        pulse_start();
        run_ticks(75, 0);
        chk("sw_sweep_1", 8'(sweep_cnt), 8'd1);
        chk("sw_shift_wrap", 8'(shift), 8'd0);
        run_ticks(224, 0);
        chk("sw_fail_299", 8'(align_fail), 8'd0);
        chk("sw_sweep_299", 8'(sweep_cnt), 8'd3);
        run_ticks(1, 0);
        chk("sw_fail_300", 8'(align_fail), 8'd1);
        chk("sw_busy_300", 8'(busy), 8'd0);
        chk("sw_sweep_300", 8'(sweep_cnt), 8'd4);
        chk("sw_shift_300", 8'(shift), 8'd0);
        run_ticks(20, 0);
        chk("sw_fail_hold", 8'(align_fail), 8'd1);
        pulse_start();
        chk("sw_restart_busy", 8'(busy), 8'd1);
        chk("sw_restart_fail", 8'(align_fail), 8'd0);
        chk("sw_restart_sweep", 8'(sweep_cnt), 8'd0);

        // Lock loss during CHECK at shift 3.
        do_reset(); target = 5'd5;
        pulse_start();
        run_ticks(19, 0);
        chk("ll_busy_check", 8'(busy), 8'd1);
        chk("ll_shift_check", 8'(shift), 8'd3);
        locked = 1'b0;
        step();
        locked = 1'b1;
        chk("ll_busy", 8'(busy), 8'd0);
        chk("ll_shift_hold", 8'(shift), 8'd3);
        run_ticks(10, 0);
        chk("ll_no_restart", 8'(busy), 8'd0);
        chk("ll_shift_idle", 8'(shift), 8'd3);

        // Manual override while aligned at shift 2.
        do_reset(); target = 5'd2;
        pulse_start();
        run_ticks(78, 0);
        chk("mn_aligned", 8'(aligned), 8'd1);
        chk("mn_shift_aligned", 8'(shift), 8'd2);
        man_en = 1'b1; man_shift = 4'd9;
        step();
        chk("mn_shift9", 8'(shift), 8'd9);
        chk("mn_aligned_clr", 8'(aligned), 8'd0);
        chk("mn_busy", 8'(busy), 8'd0);
        man_shift = 4'd15;
        step();
        chk("mn_shift15_clamp", 8'(shift), 8'd0);
        man_en = 1'b0;
        step();
        chk("mn_exit_busy", 8'(busy), 8'd0);
        chk("mn_exit_aligned", 8'(aligned), 8'd0);

        // Sparse ticks at shift 0: same 68-tick count.
        do_reset(); target = 5'd0;
        pulse_start();
        run_ticks(67, 3);
        chk("sp_not_aligned_67", 8'(aligned), 8'd0);
        chk("sp_busy_67", 8'(busy), 8'd1);
        chk("sp_shift_67", 8'(shift), 8'd0);
        run_ticks(1, 0);
        chk("sp_aligned_68", 8'(aligned), 8'd1);

        // Start coincident with lock loss while aligned.
        start = 1'b1; locked = 1'b0;
        step();
        start = 1'b0; locked = 1'b1;
        chk("sl_aligned", 8'(aligned), 8'd0);
        chk("sl_busy", 8'(busy), 8'd0);
        run_ticks(10, 0);
        chk("sl_no_search", 8'(busy), 8'd0);

        // Reset during CHECK at shift 1.
        do_reset(); target = 5'd5;
        pulse_start();
        run_ticks(9, 0);
        chk("rs_busy_pre", 8'(busy), 8'd1);
        chk("rs_shift_pre", 8'(shift), 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_shift", 8'(shift), 8'd0);
        chk("rs_busy", 8'(busy), 8'd0);
        chk("rs_aligned", 8'(aligned), 8'd0);
        chk("rs_fail", 8'(align_fail), 8'd0);
        chk("rs_sweep", 8'(sweep_cnt), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
